sprite_row_controller: RTL and testbench

SPRITE_ROW_CONTROLLER -- requirements
Module: sprite_row_controller

---
 rtl/sprite_row_controller_pkg.sv | 17 +
 rtl/define.v | 10 +
 rtl/sprite_slot_match.sv | 28 ++
 rtl/sprite_row_controller.sv | 161 ++++++++++++++++
 tb/tb_sprite_row_controller.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/sprite_row_controller_pkg.sv
// Shared constants and helpers for the sprite row controller.
//   CORD_W     : screen coordinate width (from define.v)
//   XW         : widened x width, so instance origins never wrap
//   min1_clog2 : index width helper, at least 1 bit
`include "define.v"

package sprite_row_controller_pkg;

  localparam int unsigned CORD_W = `CORDW;
  localparam int unsigned XW     = CORD_W + 8;

  // Width needed to index n items, never less than one bit
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/define.v
// Shared screen/coordinate constants used across the video pipeline.
//   CORDW : coordinate width for pixel/line counters
//   H_RES : active horizontal resolution
//   V_RES : active vertical resolution
`ifndef SPRITE_DEFINE_V
`define SPRITE_DEFINE_V
`define CORDW 16
`define H_RES 640
`define V_RES 480
`endif

// File: rtl/sprite_slot_match.sv
// Horizontal window compare for one sprite instance.
//   x     : current pixel x, widened to XW
//   ox    : instance x origin, widened to XW
//   en    : instance alive and current line inside the sprite rows
//   hit_c : pixel lies inside [ox, ox+SPR_W-1] and en is set
//   col_c : column offset x-ox, valid when hit_c
module sprite_slot_match
  import sprite_row_controller_pkg::*;
#(
  parameter int unsigned SPR_W = 16
) (
  input  logic [XW-1:0]                  x,
  input  logic [XW-1:0]                  ox,
  input  logic                           en,
  output logic                           hit_c,
  output logic [min1_clog2(SPR_W)-1:0]   col_c
);

  localparam int unsigned CW = min1_clog2(SPR_W);

  logic [XW-1:0] dx;

  // Subtract-then-bound avoids computing ox+SPR_W-1, which could carry out
  assign dx    = x - ox;
  assign hit_c = en && (x >= ox) && (dx <= XW'(SPR_W - 1));
  assign col_c = CW'(dx);

endmodule

// File: rtl/sprite_row_controller.sv
// Sprite row controller: draws N_SPR copies of one sprite in a horizontal
// row, producing a sprite ROM address for the pixel being scanned.
// Optional animation (two-frame flip every ANIM_PERIOD video frames) is
// enabled by defining SPRITE_ANIM_EN; otherwise frame is tied to 0.
//   clk, rst_n         : clock, asynchronous active-low reset
//   pixel, line        : current scan coordinate
//   origin_x, origin_y : row placement, sampled at frame start
//   alive              : per-instance enable mask, sampled at frame start
//   addr, rden         : registered ROM address and read enable
//   hit_idx            : registered index of the drawn instance
//   frame              : current animation frame
module sprite_row_controller
  import sprite_row_controller_pkg::*;
#(
  parameter int unsigned SPR_W       = 16,
  parameter int unsigned SPR_H       = 8,
  parameter int unsigned N_SPR       = 8,
  parameter int unsigned SPACING     = 24,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned ANIM_PERIOD = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CORD_W-1:0]             pixel,
  input  logic [CORD_W-1:0]             line,
  input  logic [CORD_W-1:0]             origin_x,
  input  logic [CORD_W-1:0]             origin_y,
  input  logic [N_SPR-1:0]              alive,
  output logic [ADDR_W-1:0]             addr,
  output logic                          rden,
  output logic [min1_clog2(N_SPR)-1:0]  hit_idx,
  output logic                          frame
);

  localparam int unsigned IW = min1_clog2(N_SPR);
  localparam int unsigned CW = min1_clog2(SPR_W);
  localparam int unsigned RW = min1_clog2(SPR_H);

  // Elaboration-time parameter sanity
  if (SPACING < 1) begin : g_bad_spacing
    $error("SPACING must be at least 1");
  end
  if (ANIM_PERIOD < 1) begin : g_bad_period
    $error("ANIM_PERIOD must be at least 1");
  end
  if (64'(2 * SPR_W * SPR_H) > (64'(1) << ADDR_W)) begin : g_bad_addr
    $error("ADDR_W too small for two sprite frames");
  end

  logic [CORD_W-1:0] shadow_x;
  logic [CORD_W-1:0] shadow_y;
  logic [N_SPR-1:0]  shadow_alive;

  logic              frame_start_c;
  logic              row_ok_c;
  logic [RW-1:0]     row_c;
  logic [XW-1:0]     pixel_x_c;
  logic [N_SPR-1:0]  slot_hit_c;
  logic [CW-1:0]     slot_col_c [N_SPR];
  logic              any_hit_c;
  logic [IW-1:0]     sel_idx_c;
  logic [CW-1:0]     sel_col_c;
  logic [ADDR_W-1:0] frame_base_c;
  logic [ADDR_W-1:0] addr_next_c;

  assign frame_start_c = (pixel == '0) && (line == '0);
  assign pixel_x_c     = XW'(pixel);

  // Row window at CORD_W+1 bits so a row near the bottom edge cannot wrap
  assign row_ok_c = ({1'b0, line} >= {1'b0, shadow_y}) &&
                    ({1'b0, line} <= ({1'b0, shadow_y} + (CORD_W + 1)'(SPR_H - 1)));
  assign row_c    = RW'(line - shadow_y);

  // Shadow copies of placement and mask, updated only at frame start
  always_ff @(posedge clk or negedge rst_n) begin : p_shadow
    if (!rst_n) begin
      shadow_x     <= '0;
      shadow_y     <= '0;
      shadow_alive <= '0;
    end else if (frame_start_c) begin
      shadow_x     <= origin_x;
      shadow_y     <= origin_y;
      shadow_alive <= alive;
    end
  end

  // One window compare per instance
  for (genvar i = 0; i < int'(N_SPR); i++) begin : g_slot
    logic [XW-1:0] ox;
    assign ox = XW'(shadow_x) + XW'(i * SPACING);

    sprite_slot_match #(
      .SPR_W (SPR_W)
    ) u_slot (
      .x     (pixel_x_c),
      .ox    (ox),
      .en    (row_ok_c && shadow_alive[i]),
      .hit_c (slot_hit_c[i]),
      .col_c (slot_col_c[i])
    );
  end

  // Priority chain: scanning high to low leaves the lowest hit selected
  always_comb begin : p_prio
    any_hit_c = 1'b0;
    sel_idx_c = '0;
    sel_col_c = '0;
    for (int i = int'(N_SPR) - 1; i >= 0; i--) begin
      if (slot_hit_c[i]) begin
        any_hit_c = 1'b1;
        sel_idx_c = IW'(i);
        sel_col_c = slot_col_c[i];
      end
    end
  end

`ifdef SPRITE_ANIM_EN
  localparam int unsigned AW = min1_clog2(ANIM_PERIOD);

  logic [AW-1:0] anim_cnt;
  logic          frame_q;

  // Count frame starts; flip the animation frame on each wrap
  always_ff @(posedge clk or negedge rst_n) begin : p_anim
    if (!rst_n) begin
      anim_cnt <= '0;
      frame_q  <= 1'b0;
    end else if (frame_start_c) begin
      if (anim_cnt == AW'(ANIM_PERIOD - 1)) begin
        anim_cnt <= '0;
        frame_q  <= ~frame_q;
      end else begin
        anim_cnt <= anim_cnt + AW'(1);
      end
    end
  end

  assign frame = frame_q;
`else
  assign frame = 1'b0;
`endif

  assign frame_base_c = frame ? ADDR_W'(SPR_W * SPR_H) : '0;
  assign addr_next_c  = frame_base_c
                      + ADDR_W'(row_c) * ADDR_W'(SPR_W)
                      + ADDR_W'(sel_col_c);

  // Registered ROM request, zeroed when nothing is drawn
  always_ff @(posedge clk or negedge rst_n) begin : p_out
    if (!rst_n) begin
      addr    <= '0;
      rden    <= 1'b0;
      hit_idx <= '0;
    end else begin
      rden    <= any_hit_c;
      addr    <= any_hit_c ? addr_next_c : '0;
      hit_idx <= any_hit_c ? sel_idx_c : '0;
    end
  end

endmodule

// File: tb/tb_sprite_row_controller.sv
// Scoreboard bench for sprite_row_controller: three instances (default,
// overlapping spacing, short animation period) share the scan inputs.
`timescale 1ns/1ps
module tb_sprite_row_controller;
  import sprite_row_controller_pkg::*;

`ifdef SPRITE_ANIM_EN
  localparam bit ANIM = 1'b1;
`else
  localparam bit ANIM = 1'b0;
`endif

  typedef struct {
    string name;
    int    cyc;
    int    dut;
    int    rden;
    int    addr;
    int    idx;
    int    frame;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CORD_W-1:0] pixel, line, origin_x, origin_y;
  logic [7:0]        alive;

  logic [11:0] addr0, addr1, addr2;
  logic        rden0, rden1, rden2;
  logic [2:0]  idx0, idx1, idx2;
  logic        frame0, frame1, frame2;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  sprite_row_controller u_dut (
    .clk(clk), .rst_n(rst_n), .pixel(pixel), .line(line),
    .origin_x(origin_x), .origin_y(origin_y), .alive(alive),
    .addr(addr0), .rden(rden0), .hit_idx(idx0), .frame(frame0)
  );

  sprite_row_controller #(.SPACING(8)) u_ov (
    .clk(clk), .rst_n(rst_n), .pixel(pixel), .line(line),
    .origin_x(origin_x), .origin_y(origin_y), .alive(alive),
    .addr(addr1), .rden(rden1), .hit_idx(idx1), .frame(frame1)
  );

  sprite_row_controller #(.ANIM_PERIOD(2)) u_an (
    .clk(clk), .rst_n(rst_n), .pixel(pixel), .line(line),
    .origin_x(origin_x), .origin_y(origin_y), .alive(alive),
    .addr(addr2), .rden(rden2), .hit_idx(idx2), .frame(frame2)
  );

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  // Apply a scan coordinate on the falling edge
  task automatic drive(input int px, input int ln);
    @(negedge clk);
    pixel = CORD_W'(px);
    line  = CORD_W'(ln);
  endtask

  // Expectation for the vector just driven, seen after the next rising edge
  task automatic expect_out(input string nm, input int d, input int r,
                            input int a, input int i, input int f);
    exp_t e;
    e.name = nm; e.cyc = cyc + 1; e.dut = d;
    e.rden = r; e.addr = a; e.idx = i; e.frame = f;
    q.push_back(e);
  endtask

  // Monitor: compare every expectation due in this cycle
  initial begin : p_monitor
    exp_t e;
    int r, a, i, f;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc < cyc) begin
          chk({e.name, "_missed"}, e.cyc, cyc);
        end else begin
          case (e.dut)
            1:       begin r = rden1; a = addr1; i = idx1; f = frame1; end
            2:       begin r = rden2; a = addr2; i = idx2; f = frame2; end
            default: begin r = rden0; a = addr0; i = idx0; f = frame0; end
          endcase
          chk({e.name, "_rden"},  r, e.rden);
          chk({e.name, "_addr"},  a, e.addr);
          chk({e.name, "_idx"},   i, e.idx);
          chk({e.name, "_frame"}, f, e.frame);
        end
      end
    end
  end

  initial begin : p_stim
    int maxc;
    int wait_cnt;
    maxc     = (1 << CORD_W) - 1;
    rst_n    = 1'b0;
    pixel    = CORD_W'(1);
    line     = CORD_W'(1);
    origin_x = CORD_W'(100);
    origin_y = CORD_W'(50);
    alive    = 8'hFF;
    #2;
    chk("reset_rden",  int'(rden0), 0);
    chk("reset_addr",  int'(addr0), 0);
    chk("reset_frame", int'(frame2), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // No hits before the first frame start loads the shadow mask
    drive(100, 50);  expect_out("pre_fs", 0, 0, 0, 0, 0);
    drive(0, 0);     expect_out("fs1", 0, 0, 0, 0, 0);
    drive(100, 50);  expect_out("origin", 0, 1, 0, 0, 0);
                     expect_out("ov_origin", 1, 1, 0, 0, 0);
                     expect_out("an_f0", 2, 1, 0, 0, 0);
    drive(149, 53);  expect_out("inst2", 0, 1, 49, 2, 0);
    drive(115, 57);  expect_out("corner", 0, 1, 127, 0, 0);
    drive(116, 50);  expect_out("gap", 0, 0, 0, 0, 0);
    drive(124, 50);  expect_out("inst1", 0, 1, 0, 1, 0);
    drive(100, 58);  expect_out("below", 0, 0, 0, 0, 0);
    drive(283, 57);  expect_out("inst7", 0, 1, 127, 7, 0);
    drive(284, 50);  expect_out("past_row", 0, 0, 0, 0, 0);
    drive(110, 50);  expect_out("ov_low", 1, 1, 10, 0, 0);
                     expect_out("plain_110", 0, 1, 10, 0, 0);
    drive(120, 50);  expect_out("ov_mid", 1, 1, 12, 1, 0);

    // Mask change mid-frame is deferred to the next frame start
    @(negedge clk);
    alive = 8'hFB;
    drive(149, 53);  expect_out("alive_defer", 0, 1, 49, 2, 0);
    drive(0, 0);     expect_out("an_fs2", 2, 0, 0, 0, ANIM ? 1 : 0);
    drive(149, 53);  expect_out("alive_off", 0, 0, 0, 0, 0);
    drive(100, 50);  expect_out("an_addr", 2, 1, ANIM ? 128 : 0, 0, ANIM ? 1 : 0);
                     expect_out("dut_f0", 0, 1, 0, 0, 0);

    // Row placed against the right screen edge: clip, never wrap to x=0
    @(negedge clk);
    origin_x = CORD_W'(maxc - 7);
    drive(0, 0);     expect_out("fs_clip", 0, 0, 0, 0, 0);
    drive(0, 50);    expect_out("no_wrap", 0, 0, 0, 0, 0);
    drive(maxc, 50); expect_out("edge", 0, 1, 7, 0, 0);

    // Asynchronous reset mid-line while drawing
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rden",  int'(rden0), 0);
    chk("async_addr",  int'(addr0), 0);
    chk("async_frame", int'(frame2), 0);
    @(negedge clk);
    rst_n = 1'b1;
    origin_x = CORD_W'(100);
    drive(maxc, 50); expect_out("post_rst", 0, 0, 0, 0, 0);
    drive(100, 50);  expect_out("post_rst2", 0, 0, 0, 0, 0);
    drive(0, 0);     expect_out("fs_after_rst", 0, 0, 0, 0, 0);
    drive(100, 50);  expect_out("redraw", 0, 1, 0, 0, 0);
    drive(5, 5);

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
